// File: rtl/bouncer_pkg.sv
// Shared widths, FSM encoding and default screen geometry for the bouncing-ball array.
package bouncer_pkg;

   localparam int unsigned POS_W          = 12;
   localparam int unsigned CNT_W          = 16;
   localparam int unsigned DEF_N_BALLS    = 4;
   localparam int unsigned DEF_H_SIZE     = 640;
   localparam int unsigned DEF_V_SIZE     = 480;
   localparam int unsigned DEF_BALL_SIZE  = 4;
   localparam int unsigned DEF_BALL_SPEED = 2;

   typedef logic signed [POS_W-1:0] pos_t;

   typedef enum logic {
      IDLE   = 1'b0,
      UPDATE = 1'b1
   } state_e;

endpackage

// File: rtl/bouncer_ball_step.sv
// One ball's per-frame step: wall reflection, velocity update, optional move and reflection count.
module bouncer_ball_step
   import bouncer_pkg::*;
#(
   parameter int unsigned H_SIZE     = DEF_H_SIZE,
   parameter int unsigned V_SIZE     = DEF_V_SIZE,
   parameter int unsigned BALL_SIZE  = DEF_BALL_SIZE,
   parameter int unsigned BALL_SPEED = DEF_BALL_SPEED
)
(
   input  logic       run,
   input  pos_t       hpos_b,
   input  pos_t       vpos_b,
   input  pos_t       hvel,
   input  pos_t       vvel,
   output pos_t       hpos_nxt_c,
   output pos_t       vpos_nxt_c,
   output pos_t       hvel_nxt_c,
   output pos_t       vvel_nxt_c,
   output logic [1:0] refl_c
);

   localparam pos_t H_LIM   = pos_t'(H_SIZE - BALL_SIZE);
   localparam pos_t V_LIM   = pos_t'(V_SIZE - BALL_SIZE);
   localparam pos_t SPD     = pos_t'(BALL_SPEED);
   localparam pos_t NEG_SPD = pos_t'(-int'(BALL_SPEED));
   localparam pos_t ZERO    = '0;

   logic h_flip;
   logic v_flip;

   // The far wall wins if a ball somehow sits past both limits.
   always_comb begin
      hvel_nxt_c = hvel;
      vvel_nxt_c = vvel;
      if (hpos_b >= H_LIM)
         hvel_nxt_c = NEG_SPD;
      else if (hpos_b <= ZERO)
         hvel_nxt_c = SPD;
      if (vpos_b >= V_LIM)
         vvel_nxt_c = NEG_SPD;
      else if (vpos_b <= ZERO)
         vvel_nxt_c = SPD;

      h_flip = hvel_nxt_c[POS_W-1] ^ hvel[POS_W-1];
      v_flip = vvel_nxt_c[POS_W-1] ^ vvel[POS_W-1];
      refl_c = 2'(h_flip) + 2'(v_flip);

      hpos_nxt_c = run ? pos_t'(hpos_b + hvel_nxt_c) : hpos_b;
      vpos_nxt_c = run ? pos_t'(vpos_b + vvel_nxt_c) : vpos_b;
   end

endmodule

// File: rtl/bouncer_array.sv
// Array of bouncing square balls drawn over a dot grid; one shared step engine
// walks the balls once per frame, starting on the falling edge of vsync.
module bouncer_array
   import bouncer_pkg::*;
#(
   parameter int unsigned N_BALLS    = DEF_N_BALLS,
   parameter int unsigned H_SIZE     = DEF_H_SIZE,
   parameter int unsigned V_SIZE     = DEF_V_SIZE,
   parameter int unsigned BALL_SIZE  = DEF_BALL_SIZE,
   parameter int unsigned BALL_SPEED = DEF_BALL_SPEED
)
(
   input  logic             CLK,
   input  logic             RST,
   input  logic [POS_W-1:0] hpos,
   input  logic [POS_W-1:0] vpos,
   input  logic             display_on,
   input  logic             vsync,
   input  logic             run,
   input  logic             restart,
   output logic             red,
   output logic             green,
   output logic             blue,
   output logic [CNT_W-1:0] bounce_count,
   output logic             busy
);

   localparam int unsigned IDX_W = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BALLS - 1);
   localparam pos_t SPD     = pos_t'(BALL_SPEED);
   localparam pos_t NEG_SPD = pos_t'(-int'(BALL_SPEED));
   localparam pos_t BS      = pos_t'(BALL_SIZE);

   state_e           state;
   logic [IDX_W-1:0] idx;
   logic             vsync_q;
   logic             frame_ev;

   pos_t ball_x  [N_BALLS];
   pos_t ball_y  [N_BALLS];
   pos_t ball_hv [N_BALLS];
   pos_t ball_vv [N_BALLS];

   pos_t cur_x, cur_y, cur_hv, cur_vv;
   pos_t nxt_x, nxt_y, nxt_hv, nxt_vv;
   logic [1:0]       refl_c;
   logic [SUM_W-1:0] cnt_sum;
   logic [CNT_W-1:0] cnt_nxt;

   logic [N_BALLS-1:0] hit;
   logic any_hit, multi_hit, even_hit, odd_hit, grid;

   function automatic pos_t init_x(input int unsigned i);
      return pos_t'(H_SIZE / 2 + 8 * i);
   endfunction

   function automatic pos_t init_hv(input int unsigned i);
      return (i % 2 == 0) ? SPD : NEG_SPD;
   endfunction

   assign frame_ev = vsync_q & ~vsync;

   // Select the ball currently being stepped and pre-compute the saturated count.
   always_comb begin
      cur_x  = '0;
      cur_y  = '0;
      cur_hv = '0;
      cur_vv = '0;
      for (int unsigned i = 0; i < N_BALLS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_x  = ball_x[i];
            cur_y  = ball_y[i];
            cur_hv = ball_hv[i];
            cur_vv = ball_vv[i];
         end
      end
      cnt_sum = SUM_W'(bounce_count) + SUM_W'(refl_c);
      cnt_nxt = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   bouncer_ball_step #(
      .H_SIZE     (H_SIZE),
      .V_SIZE     (V_SIZE),
      .BALL_SIZE  (BALL_SIZE),
      .BALL_SPEED (BALL_SPEED)
   ) u_step (
      .run        (run),
      .hpos_b     (cur_x),
      .vpos_b     (cur_y),
      .hvel       (cur_hv),
      .vvel       (cur_vv),
      .hpos_nxt_c (nxt_x),
      .vpos_nxt_c (nxt_y),
      .hvel_nxt_c (nxt_hv),
      .vvel_nxt_c (nxt_vv),
      .refl_c     (refl_c)
   );

   // Frame FSM, ball storage and reflection counter.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state        <= IDLE;
         idx          <= '0;
         busy         <= 1'b0;
         bounce_count <= '0;
         vsync_q      <= 1'b1;
         for (int unsigned i = 0; i < N_BALLS; i++) begin
            ball_x[i]  <= init_x(i);
            ball_y[i]  <= pos_t'(V_SIZE / 2);
            ball_hv[i] <= init_hv(i);
            ball_vv[i] <= SPD;
         end
      end else begin
         vsync_q <= vsync;
         if (restart) begin
            state        <= IDLE;
            idx          <= '0;
            busy         <= 1'b0;
            bounce_count <= '0;
            for (int unsigned i = 0; i < N_BALLS; i++) begin
               ball_x[i]  <= init_x(i);
               ball_y[i]  <= pos_t'(V_SIZE / 2);
               ball_hv[i] <= init_hv(i);
               ball_vv[i] <= SPD;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (frame_ev) begin
                     state <= UPDATE;
                     idx   <= '0;
                     busy  <= 1'b1;
                  end
               end
               UPDATE: begin
                  for (int unsigned i = 0; i < N_BALLS; i++) begin
                     if (idx == IDX_W'(i)) begin
                        ball_x[i]  <= nxt_x;
                        ball_y[i]  <= nxt_y;
                        ball_hv[i] <= nxt_hv;
                        ball_vv[i] <= nxt_vv;
                     end
                  end
                  bounce_count <= cnt_nxt;
                  if (idx == LAST_IDX) begin
                     state <= IDLE;
                     idx   <= '0;
                     busy  <= 1'b0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Beam-vs-ball overlap, computed in wrapping 12-bit signed arithmetic.
   for (genvar g = 0; g < N_BALLS; g++) begin : g_hit
      pos_t dh;
      pos_t dv;
      assign dh     = pos_t'($signed(hpos) - ball_x[g]);
      assign dv     = pos_t'($signed(vpos) - ball_y[g]);
      assign hit[g] = !dh[POS_W-1] && (dh < BS) && !dv[POS_W-1] && (dv < BS);
   end

   always_comb begin
      any_hit   = 1'b0;
      multi_hit = 1'b0;
      even_hit  = 1'b0;
      odd_hit   = 1'b0;
      for (int unsigned i = 0; i < N_BALLS; i++) begin
         if (hit[i]) begin
            multi_hit = multi_hit | any_hit;
            any_hit   = 1'b1;
            if (i % 2 == 0)
               even_hit = 1'b1;
            else
               odd_hit = 1'b1;
         end
      end
      grid = (hpos[2:0] == 3'd0) && (vpos[2:0] == 3'd0);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         red   <= 1'b0;
         green <= 1'b0;
         blue  <= 1'b0;
      end else if (!display_on) begin
         red   <= 1'b0;
         green <= 1'b0;
         blue  <= 1'b0;
      end else if (multi_hit) begin
         red   <= 1'b1;
         green <= 1'b1;
         blue  <= 1'b1;
      end else begin
         red   <= even_hit;
         green <= grid | any_hit;
         blue  <= odd_hit;
      end
   end

endmodule

// File: tb/tb_bouncer_array.sv
// Bench for bouncer_array: default-geometry and tiny-screen instances share one stimulus,
// checked every cycle against a frame-level model plus hand-computed positions and colours.
module tb_bouncer_array;
   import bouncer_pkg::*;

   localparam int NI = 2;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic [11:0] hpos = '0;
   logic [11:0] vpos = '0;
   logic display_on = 1'b0;
   logic vsync      = 1'b1;
   logic run        = 1'b1;
   logic restart    = 1'b0;

   logic red, green, blue, busy;
   logic [15:0] bounce_count;
   logic red_s, green_s, blue_s, busy_s;
   logic [15:0] bounce_count_s;

   always #5 CLK = ~CLK;

   bouncer_array dut (
      .CLK(CLK), .RST(RST), .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .vsync(vsync), .run(run), .restart(restart), .red(red), .green(green),
      .blue(blue), .bounce_count(bounce_count), .busy(busy)
   );

   bouncer_array #(.N_BALLS(1), .H_SIZE(32), .V_SIZE(32)) dut_s (
      .CLK(CLK), .RST(RST), .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .vsync(vsync), .run(run), .restart(restart), .red(red_s), .green(green_s),
      .blue(blue_s), .bounce_count(bounce_count_s), .busy(busy_s)
   );

   // Frame-level model: a whole frame's balls are stepped at once when the update finishes.
   int nb  [NI] = '{4, 1};
   int hsz [NI] = '{640, 32};
   int vsz [NI] = '{480, 32};
   int mx  [NI][4];
   int my  [NI][4];
   int mvx [NI][4];
   int mvy [NI][4];
   int mcnt  [NI];
   int mbusy [NI];
   int exp_rgb [NI];
   bit rgb_valid [NI];
   int mprev;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void init_balls(input int k);
      for (int i = 0; i < 4; i++) begin
         mx[k][i]  = hsz[k] / 2 + 8 * i;
         my[k][i]  = vsz[k] / 2;
         mvx[k][i] = (i % 2 == 0) ? 2 : -2;
         mvy[k][i] = 2;
      end
      mcnt[k]  = 0;
      mbusy[k] = 0;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NI; k++) begin
         init_balls(k);
         exp_rgb[k]   = 0;
         rgb_valid[k] = 1'b1;
      end
      mprev = 1;
   endfunction

   function automatic void frame_apply(input int k, input bit mv);
      int b = 0;
      int nvx, nvy;
      for (int i = 0; i < nb[k]; i++) begin
         nvx = (mx[k][i] >= hsz[k] - 4) ? -2 : (mx[k][i] <= 0) ? 2 : mvx[k][i];
         nvy = (my[k][i] >= vsz[k] - 4) ? -2 : (my[k][i] <= 0) ? 2 : mvy[k][i];
         if ((nvx < 0) != (mvx[k][i] < 0)) b++;
         if ((nvy < 0) != (mvy[k][i] < 0)) b++;
         mvx[k][i] = nvx;
         mvy[k][i] = nvy;
         if (mv) begin
            mx[k][i] += nvx;
            my[k][i] += nvy;
         end
      end
      mcnt[k] = (mcnt[k] + b > 65535) ? 65535 : mcnt[k] + b;
   endfunction

   function automatic int colours(input int k);
      int h = int'($signed(hpos));
      int v = int'($signed(vpos));
      int hits = 0;
      bit ev = 0, od = 0, gr;
      if (!display_on) return 0;
      for (int i = 0; i < nb[k]; i++) begin
         if (h - mx[k][i] >= 0 && h - mx[k][i] < 4 && v - my[k][i] >= 0 && v - my[k][i] < 4) begin
            hits++;
            if (i % 2 == 0) ev = 1; else od = 1;
         end
      end
      gr = ((h % 8) == 0) && ((v % 8) == 0) || (hits > 0);
      if (hits >= 2) return 7;
      return {29'd0, ev, gr, od};
   endfunction

   function automatic void model_edge();
      if (!RST) begin
         model_reset();
         return;
      end
      for (int k = 0; k < NI; k++) begin
         rgb_valid[k] = (mbusy[k] == 0);
         exp_rgb[k]   = colours(k);
         if (restart) begin
            init_balls(k);
         end else if (mbusy[k] > 0) begin
            mbusy[k]--;
            if (mbusy[k] == 0) frame_apply(k, run);
         end else if (mprev == 1 && vsync == 1'b0) begin
            mbusy[k] = nb[k];
         end
      end
      mprev = int'(vsync);
   endfunction

   always @(negedge RST) model_reset();

   // Per-cycle comparison against the model.
   always @(posedge CLK) begin
      model_edge();
      #1;
      check("busy", int'(busy), int'(mbusy[0] > 0));
      check("busy_s", int'(busy_s), int'(mbusy[1] > 0));
      check("bounce_count", int'(bounce_count), mcnt[0]);
      check("bounce_count_s", int'(bounce_count_s), mcnt[1]);
      if (rgb_valid[0]) check("rgb", int'({red, green, blue}), exp_rgb[0]);
      if (rgb_valid[1]) check("rgb_s", int'({red_s, green_s, blue_s}), exp_rgb[1]);
      if (mbusy[0] == 0) begin
         check("ball0_x", int'(dut.ball_x[0]), mx[0][0]);
         check("ball0_y", int'(dut.ball_y[0]), my[0][0]);
         check("ball1_x", int'(dut.ball_x[1]), mx[0][1]);
         check("ball1_y", int'(dut.ball_y[1]), my[0][1]);
         check("ball2_x", int'(dut.ball_x[2]), mx[0][2]);
         check("ball3_x", int'(dut.ball_x[3]), mx[0][3]);
      end
      if (mbusy[1] == 0) begin
         check("ball_s_x", int'(dut_s.ball_x[0]), mx[1][0]);
         check("ball_s_y", int'(dut_s.ball_y[0]), my[1][0]);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic frame();
      vsync = 1'b0;
      tick(1);
      vsync = 1'b1;
      tick(7);
   endtask

   task automatic do_restart();
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
   endtask

   task automatic check_ball(input string name, input int x, input int y, input int ex, input int ey);
      check({name, "_x"}, x, ex);
      check({name, "_y"}, y, ey);
   endtask

   typedef struct { int h; int v; int rgb; } cvec_t;
   cvec_t cvec [8] = '{
      '{321, 241, 6}, '{330, 243, 3}, '{8, 16, 2}, '{324, 240, 0},
      '{323, 243, 6}, '{320, 239, 0}, '{337, 241, 6}, '{345, 242, 3}
   };

   initial begin
      int bc, bcs;
      // Reset state
      tick(2);
      check("rst_rgb", int'({red, green, blue}), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_count", int'(bounce_count), 0);
      check_ball("rst_b0", int'(dut.ball_x[0]), int'(dut.ball_y[0]), 320, 240);
      check_ball("rst_b1", int'(dut.ball_x[1]), int'(dut.ball_y[1]), 328, 240);
      check_ball("rst_s", int'(dut_s.ball_x[0]), int'(dut_s.ball_y[0]), 16, 16);

      RST = 1'b1;
      tick(3);
      check("release_busy", int'(busy), 0);

      // First frame: busy length and first move
      bc = 0;
      bcs = 0;
      vsync = 1'b0;
      tick(1);
      vsync = 1'b1;
      for (int j = 0; j < 8; j++) begin
         if (busy) bc++;
         if (busy_s) bcs++;
         tick(1);
      end
      check("busy_cycles", bc, 4);
      check("busy_cycles_s", bcs, 1);
      check_ball("f1_b0", int'(dut.ball_x[0]), int'(dut.ball_y[0]), 322, 242);
      check_ball("f1_b1", int'(dut.ball_x[1]), int'(dut.ball_y[1]), 326, 242);
      check_ball("f1_s", int'(dut_s.ball_x[0]), int'(dut_s.ball_y[0]), 18, 18);

      // Overlapping balls light all three colours; blanking clears them
      frame();
      hpos = 12'd324;
      vpos = 12'd245;
      display_on = 1'b1;
      tick(1);
      check("overlap_rgb", int'({red, green, blue}), 7);
      display_on = 1'b0;
      tick(1);
      check("blank_rgb", int'({red, green, blue}), 0);

      // Frozen frames, then one running frame
      do_restart();
      run = 1'b0;
      repeat (3) frame();
      check_ball("frz_b0", int'(dut.ball_x[0]), int'(dut.ball_y[0]), 320, 240);
      check_ball("frz_b1", int'(dut.ball_x[1]), int'(dut.ball_y[1]), 328, 240);
      run = 1'b1;
      frame();
      check_ball("run_b0", int'(dut.ball_x[0]), int'(dut.ball_y[0]), 322, 242);

      // Colour patterns around the initial ball positions
      do_restart();
      display_on = 1'b1;
      for (int j = 0; j < 8; j++) begin
         hpos = 12'(cvec[j].h);
         vpos = 12'(cvec[j].v);
         tick(1);
         check($sformatf("rgb_vec%0d", j), int'({red, green, blue}), cvec[j].rgb);
      end
      display_on = 1'b0;

      // Wall reflection on the small screen
      do_restart();
      repeat (6) frame();
      check_ball("f6_s", int'(dut_s.ball_x[0]), int'(dut_s.ball_y[0]), 28, 28);
      frame();
      check_ball("f7_s", int'(dut_s.ball_x[0]), int'(dut_s.ball_y[0]), 26, 26);
      check("f7_count_s", int'(bounce_count_s), 2);
      check("f7_count", int'(bounce_count), 0);
      check_ball("f7_b0", int'(dut.ball_x[0]), int'(dut.ball_y[0]), 334, 254);

      // Restart during the second busy cycle aborts the update
      vsync = 1'b0;
      tick(1);
      vsync = 1'b1;
      tick(1);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_count_s", int'(bounce_count_s), 0);
      check_ball("abort_b0", int'(dut.ball_x[0]), int'(dut.ball_y[0]), 320, 240);
      check_ball("abort_b1", int'(dut.ball_x[1]), int'(dut.ball_y[1]), 328, 240);
      check_ball("abort_s", int'(dut_s.ball_x[0]), int'(dut_s.ball_y[0]), 16, 16);

      // Asynchronous reset in the middle of a frame update
      frame();
      hpos = 12'd0;
      vpos = 12'd0;
      display_on = 1'b1;
      tick(1);
      check("grid_green", int'({red, green, blue}), 2);
      vsync = 1'b0;
      tick(1);
      vsync = 1'b1;
      #2;
      RST = 1'b0;
      #1;
      check("arst_rgb", int'({red, green, blue}), 0);
      check("arst_busy", int'(busy), 0);
      check_ball("arst_b0", int'(dut.ball_x[0]), int'(dut.ball_y[0]), 320, 240);
      tick(1);
      RST = 1'b1;
      display_on = 1'b0;
      tick(3);
      check("post_rst_busy", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
